// File: rtl/imm_pkg.sv
// Shared definitions for the RV32I immediate generator: the output width and
// the immSrc format encoding used by the decode stage.
package imm_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_U = 3'd2,
      IMM_B = 3'd3,
      IMM_J = 3'd4
   } immSrc_e;

endpackage

// File: rtl/imm_extend_comb.sv
// Pure combinational immediate extraction and sign-extension from instr[31:7].
// inmGen[i] carries instr[i+7], so instr[31] (the sign bit) sits at inmGen[24].
module imm_extend_comb
   import imm_pkg::*;
(
   input  logic [24:0]     inmGen,
   input  logic [2:0]      immSrc,
   output logic [XLEN-1:0] imm
);

   logic signBit;

   assign signBit = inmGen[24];

   // Select and reassemble the immediate fields; reserved codes yield zero so
   // nothing undefined leaks into execute.
   always_comb begin
      imm = '0;
      case (immSrc)
         IMM_I:   imm = {{20{signBit}}, inmGen[24:13]};
         IMM_S:   imm = {{20{signBit}}, inmGen[24:18], inmGen[4:0]};
         IMM_U:   imm = {inmGen[24:5], 12'b0};
         IMM_B:   imm = {{19{signBit}}, signBit, inmGen[0], inmGen[23:18],
                         inmGen[4:1], 1'b0};
         IMM_J:   imm = {{11{signBit}}, signBit, inmGen[12:5], inmGen[13],
                         inmGen[23:14], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/immediate_generator.sv
// Decode-stage immediate generator: combinational extraction followed by a
// single output register at the decode/execute boundary. immExt only updates
// on valid inputs; out_valid marks the cycle a fresh result is presented.
module immediate_generator
   import imm_pkg::*;
#(
   parameter int XLEN = imm_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [24:0]     inmGen,
   input  logic [2:0]      immSrc,
   input  logic            in_valid,
   output logic [XLEN-1:0] immExt,
   output logic            out_valid
);

   logic [XLEN-1:0] immNext;

   imm_extend_comb uExtend (
      .inmGen (inmGen),
      .immSrc (immSrc),
      .imm    (immNext)
   );

   // Output register: reset wins, valid inputs load, otherwise hold the value
   // and drop out_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         immExt    <= '0;
         out_valid <= 1'b0;
      end else if (in_valid) begin
         immExt    <= immNext;
         out_valid <= 1'b1;
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_immediate_generator.sv
// Scoreboard bench for immediate_generator: each stimulus cycle pushes the
// expected registered response; a negedge monitor pops and compares.
module tb_immediate_generator;
   import imm_pkg::*;

   logic        clk;
   logic        rst;
   logic [24:0] inmGen;
   logic [2:0]  immSrc;
   logic        in_valid;
   logic [31:0] immExt;
   logic        out_valid;

   typedef struct {
      logic        expValid;
      logic        chkImm;
      logic [31:0] expImm;
      string       name;
   } exp_t;

   exp_t expQ[$];

   int errors = 0;
   int checks = 0;

   immediate_generator dut (
      .clk       (clk),
      .rst       (rst),
      .inmGen    (inmGen),
      .immSrc    (immSrc),
      .in_valid  (in_valid),
      .immExt    (immExt),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: one expectation per clock edge, compared half a cycle later.
   always @(negedge clk) begin
      exp_t e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checks = checks + 1;
         if (out_valid !== e.expValid) begin
            errors = errors + 1;
            $display("FAIL %s out_valid: got %b expected %b", e.name, out_valid, e.expValid);
         end
         if (e.chkImm) begin
            checks = checks + 1;
            if (immExt !== e.expImm) begin
               errors = errors + 1;
               $display("FAIL %s immExt: got %h expected %h", e.name, immExt, e.expImm);
            end
         end
      end else if (out_valid === 1'b1) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL unexpected_output: out_valid=1 immExt=%h with no expectation queued", immExt);
      end
   end

   // Drive one cycle of inputs, then queue what the register must show after
   // that edge.
   task automatic cyc(input logic r, input logic v, input logic [24:0] g,
                      input logic [2:0] src, input logic eValid,
                      input logic eChk, input logic [31:0] eImm,
                      input string name);
      exp_t e;
      rst      = r;
      in_valid = v;
      inmGen   = g;
      immSrc   = src;
      @(posedge clk);
      #1;
      e.expValid = eValid;
      e.chkImm   = eChk;
      e.expImm   = eImm;
      e.name     = name;
      expQ.push_back(e);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b1;
      inmGen   = 25'h1ABCDEF;
      immSrc   = 3'd0;

      cyc(1'b1, 1'b1, 25'h1ABCDEF, 3'd0, 1'b0, 1'b1, 32'h0, "reset_0");
      cyc(1'b1, 1'b1, 25'h0F0F0F0, 3'd4, 1'b0, 1'b1, 32'h0, "reset_1");

      cyc(1'b0, 1'b1, 25'h0012345, IMM_I, 1'b1, 1'b1, 32'h0000_0009, "i_pos");
      cyc(1'b0, 1'b1, 25'h1FFE000, IMM_I, 1'b1, 1'b1, 32'hFFFF_FFFF, "i_neg");
      cyc(1'b0, 1'b1, 25'h006789A, IMM_U, 1'b1, 1'b1, 32'h033C_4000, "u_type");
      cyc(1'b0, 1'b1, 25'h1FFFFFF, IMM_S, 1'b1, 1'b1, 32'hFFFF_FFFF, "s_ones");
      cyc(1'b0, 1'b1, 25'h1FFFFFF, IMM_B, 1'b1, 1'b1, 32'hFFFF_FFFE, "b_ones");
      cyc(1'b0, 1'b1, 25'h1FFFFFF, IMM_J, 1'b1, 1'b1, 32'hFFFF_FFFE, "j_ones");
      cyc(1'b0, 1'b1, 25'h0000001, IMM_B, 1'b1, 1'b1, 32'h0000_0800, "b_bit11");
      cyc(1'b0, 1'b1, 25'h0002000, IMM_J, 1'b1, 1'b1, 32'h0000_0800, "j_bit11");
      cyc(1'b0, 1'b1, 25'h000001F, IMM_S, 1'b1, 1'b1, 32'h0000_001F, "s_low");
      cyc(1'b0, 1'b1, 25'h1000000, IMM_B, 1'b1, 1'b1, 32'hFFFF_F000, "b_sign");
      cyc(1'b0, 1'b1, 25'h1000000, IMM_J, 1'b1, 1'b1, 32'hFFF0_0000, "j_sign");

      cyc(1'b0, 1'b0, 25'h0012345, IMM_I, 1'b0, 1'b1, 32'hFFF0_0000, "hold_nonzero");

      cyc(1'b0, 1'b1, 25'h1FFFFFF, IMM_S, 1'b1, 1'b1, 32'hFFFF_FFFF, "pre_reset");
      cyc(1'b1, 1'b1, 25'h1FFFFFF, IMM_B, 1'b0, 1'b1, 32'h0, "mid_reset");
      cyc(1'b0, 1'b1, 25'h0012345, IMM_I, 1'b1, 1'b1, 32'h0000_0009, "post_reset");

      cyc(1'b0, 1'b1, 25'h1FFFFFF, 3'b101, 1'b1, 1'b1, 32'h0, "rsv_101");
      cyc(1'b0, 1'b1, 25'h1FFFFFF, 3'b110, 1'b1, 1'b1, 32'h0, "rsv_110");
      cyc(1'b0, 1'b1, 25'h1FFFFFF, 3'b111, 1'b1, 1'b1, 32'h0, "rsv_111");
      cyc(1'b0, 1'b0, 25'h006789A, IMM_U, 1'b0, 1'b1, 32'h0, "hold_zero");
      cyc(1'b0, 1'b0, 25'h0000000, IMM_I, 1'b0, 1'b1, 32'h0, "idle");

      for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clk);
      if (expQ.size() > 0) begin
         $display("FAIL drain: %0d expectations left unconsumed, expected 0", expQ.size());
         $fatal(1, "scoreboard did not drain");
      end
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
